// File: rtl/shift_deser8.sv
// shift_deser8: serial-to-parallel receiver assembling 8-bit words (LSB- or MSB-first) with a valid/ready output buffer.
// Define PARITY_EN to append a 9th even-parity bit per word and enable the parity_err flag.
module shift_deser8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       sin,
   input  logic       sin_valid,
   input  logic       sof,
   input  logic       dir,
   input  logic       po_ready,
   input  logic       clr_err,
   output logic [7:0] PO,
   output logic       po_valid,
   output logic       overrun,
   output logic       frame_err,
   output logic       parity_err
);

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic [7:0]  sreg;
   logic        dir_q;

   logic        start;
   logic        dir_sel;
   logic [7:0]  shifted;
   logic        last_data;
   logic        deliver;
   logic [7:0]  word;
   logic        frame_set;
   logic        overrun_set;
   logic        accept;
`ifdef PARITY_EN
   logic        parity_set;
`endif

   // A sof bit always begins a frame, so it uses the live dir rather than the latched one.
   assign start     = sin_valid && sof;
   assign dir_sel   = start ? dir : dir_q;
   assign shifted   = dir_sel ? {sreg[6:0], sin} : {sin, sreg[7:1]};
   assign last_data = (state == SHIFT) && sin_valid && !sof && (cnt == 3'd7);
   assign accept    = po_valid && po_ready;

   // NOTE: state and datapath flops use non-blocking assignments so every register updates together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every variable gets a default at the top of the block so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = SHIFT;
`ifdef PARITY_EN
         SHIFT: if (last_data) state_nxt = PAR;
         PAR: begin
            if (start)          state_nxt = SHIFT;
            else if (sin_valid) state_nxt = IDLE;
         end
`else
         SHIFT: if (last_data) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      deliver   = 1'b0;
      word      = shifted;
      frame_set = 1'b0;
`ifdef PARITY_EN
      parity_set = 1'b0;
`endif
      case (state)
         SHIFT: begin
            frame_set = start;
`ifndef PARITY_EN
            deliver   = last_data;
`endif
         end
`ifdef PARITY_EN
         PAR: begin
            frame_set = start;
            if (sin_valid && !sof) begin
               deliver    = 1'b1;
               word       = sreg;
               parity_set = ^{sreg, sin};
            end
         end
`endif
         default: ;
      endcase
   end

   assign overrun_set = deliver && po_valid && !po_ready;

   // The parity bit itself is not shifted in; sreg keeps the data word while in PAR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg  <= 8'h00;
         cnt   <= 3'd0;
         dir_q <= 1'b0;
      end else if (sin_valid && (sof || state == SHIFT)) begin
         sreg <= shifted;
         cnt  <= sof ? 3'd1 : cnt + 3'd1;
         if (sof) dir_q <= dir;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PO       <= 8'h00;
         po_valid <= 1'b0;
      end else if (deliver && (!po_valid || po_ready)) begin
         PO       <= word;
         po_valid <= 1'b1;
      end else if (accept) begin
         po_valid <= 1'b0;
      end
   end

   // A flag being set in the same cycle as clr_err stays set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= overrun_set || (overrun && !clr_err);
         frame_err <= frame_set || (frame_err && !clr_err);
      end
   end

`ifdef PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_err <= 1'b0;
      else     parity_err <= parity_set || (parity_err && !clr_err);
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser8.sv
// Testbench for shift_deser8: directed scenarios plus randomized frames checked against a queue-based frame model.
// Build with PARITY_EN defined to exercise the parity variant.
module tb_shift_deser8;

`ifdef PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       sin, sin_valid, sof, dir, po_ready, clr_err;
   logic [7:0] PO;
   logic       po_valid, overrun, frame_err, parity_err;

   always #5 clk = ~clk;

   shift_deser8 dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .sof        (sof),
      .dir        (dir),
      .po_ready   (po_ready),
      .clr_err    (clr_err),
      .PO         (PO),
      .po_valid   (po_valid),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   typedef struct {
      bit sin;
      bit sv;
      bit sof;
      bit dir;
      bit rdy;
      bit clr;
   } cyc_t;

   // Model: bits of the frame in progress, plus the output buffer and sticky flags.
   bit         fq[$];
   bit         fdir;
   logic [7:0] m_po;
   bit         m_valid, m_ov, m_fe, m_pe;
   int         checks = 0;
   int         errors = 0;

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic cyc_t mk(input bit s, input bit v, input bit f, input bit d, input bit r, input bit c);
      cyc_t x;
      x.sin = s; x.sv = v; x.sof = f; x.dir = d; x.rdy = r; x.clr = c;
      return x;
   endfunction

   task automatic model_reset();
      fq.delete();
      fdir    = 1'b0;
      m_po    = 8'h00;
      m_valid = 1'b0;
      m_ov    = 1'b0;
      m_fe    = 1'b0;
      m_pe    = 1'b0;
   endtask

   // Called just after a falling edge: drive one cycle, advance the model, wait for the next falling edge.
   task automatic tick(input cyc_t c);
      bit         complete, fe_set, pe_set, ov_set;
      logic [7:0] w;
      int         ones;
      complete = 1'b0; fe_set = 1'b0; pe_set = 1'b0; ov_set = 1'b0; w = 8'h00; ones = 0;
      sin = c.sin; sin_valid = c.sv; sof = c.sof; dir = c.dir; po_ready = c.rdy; clr_err = c.clr;
      if (c.sv) begin
         if (c.sof) begin
            fe_set = (fq.size() != 0);
            fq.delete();
            fq.push_back(c.sin);
            fdir = c.dir;
         end else if (fq.size() != 0) begin
            fq.push_back(c.sin);
            if (fq.size() == NB) begin
               complete = 1'b1;
               for (int i = 0; i < 8; i++) if (fq[i]) w[fdir ? 7 - i : i] = 1'b1;
               foreach (fq[i]) ones += int'(fq[i]);
               pe_set = (NB == 9) && (ones % 2 == 1);
               fq.delete();
            end
         end
      end
      if (complete) begin
         if (!m_valid || c.rdy) begin
            m_po    = w;
            m_valid = 1'b1;
         end else begin
            ov_set = 1'b1;
         end
      end else if (m_valid && c.rdy) begin
         m_valid = 1'b0;
      end
      m_ov = ov_set || (m_ov && !c.clr);
      m_fe = fe_set || (m_fe && !c.clr);
      m_pe = pe_set || (m_pe && !c.clr);
      @(negedge clk);
   endtask

   task automatic idle(input bit r, input bit c);
      tick(mk(1'b0, 1'b0, 1'b0, 1'b0, r, c));
   endtask

   task automatic send_word(input logic [7:0] w, input bit d, input int gap, input bit rdy,
                            input bit rdy_last, input bit bad_par);
      bit bits[$];
      for (int i = 0; i < 8; i++) bits.push_back(d ? w[7 - i] : w[i]);
      if (NB == 9) bits.push_back((^w) ^ bad_par);
      foreach (bits[i]) begin
         if (i > 0) repeat (gap) tick(mk(1'b0, 1'b0, 1'b0, d, rdy, 1'b0));
         tick(mk(bits[i], 1'b1, i == 0, d, (i == bits.size() - 1) ? rdy_last : rdy, 1'b0));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; dir = 1'b0; po_ready = 1'b0; clr_err = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({PO, po_valid, overrun, frame_err, parity_err} !== 12'h000) begin
         errors++;
         $display("FAIL reset_values: got PO=%h v=%b ov=%b fe=%b pe=%b, want all zero", PO, po_valid, overrun, frame_err, parity_err);
      end
      rst = 1'b0;
      // Four bits of a frame, then an asynchronous reset in the middle of the cycle.
      for (int i = 0; i < 4; i++) tick(mk(1'b1, 1'b1, i == 0, 1'b0, 1'b0, 1'b0));
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({PO, po_valid, overrun, frame_err} !== 11'h000) begin
         errors++;
         $display("FAIL reset_midframe: got PO=%h v=%b ov=%b fe=%b, want all zero", PO, po_valid, overrun, frame_err);
      end
      @(negedge clk);
      rst = 1'b0;
      // Without sof these must be ignored; a surviving partial word would complete here.
      for (int i = 0; i < 5; i++) tick(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      checks++;
      if (po_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_delivery: got po_valid=%b want 0", po_valid);
      end
      send_word(8'h5A, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (PO !== 8'h5A || po_valid !== 1'b1 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_next_frame: got PO=%h v=%b fe=%b want PO=5a v=1 fe=0", PO, po_valid, frame_err);
      end
      idle(1'b1, 1'b0);
   endtask

   task automatic test_lsb_first();
      send_word(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (PO !== 8'hA5 || po_valid !== 1'b1) begin
         errors++;
         $display("FAIL lsb_word: got PO=%h v=%b want PO=a5 v=1", PO, po_valid);
      end
      checks++;
      if ({overrun, frame_err, parity_err} !== 3'b000) begin
         errors++;
         $display("FAIL lsb_flags: got ov/fe/pe=%b want 000", {overrun, frame_err, parity_err});
      end
      idle(1'b1, 1'b0);
      checks++;
      if (po_valid !== 1'b0 || PO !== 8'hA5) begin
         errors++;
         $display("FAIL lsb_consume: got v=%b PO=%h want v=0 PO=a5", po_valid, PO);
      end
   endtask

   task automatic test_msb_gaps();
      send_word(8'h3C, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      checks++;
      if (PO !== 8'h3C || po_valid !== 1'b1 || {overrun, frame_err, parity_err} !== 3'b000) begin
         errors++;
         $display("FAIL msb_gaps: got PO=%h v=%b flags=%b want PO=3c v=1 flags=000", PO, po_valid, {overrun, frame_err, parity_err});
      end
      idle(1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      send_word(8'h11, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (PO !== 8'h11 || po_valid !== 1'b1 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL b2b_overrun: got PO=%h v=%b ov=%b want PO=11 v=1 ov=1", PO, po_valid, overrun);
      end
      idle(1'b0, 1'b1);
      checks++;
      if (overrun !== 1'b0 || PO !== 8'h11) begin
         errors++;
         $display("FAIL b2b_clr: got ov=%b PO=%h want ov=0 PO=11", overrun, PO);
      end
      idle(1'b1, 1'b0);
      send_word(8'h11, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (PO !== 8'h22 || po_valid !== 1'b1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain_same_cycle: got PO=%h v=%b ov=%b want PO=22 v=1 ov=0", PO, po_valid, overrun);
      end
      idle(1'b1, 1'b0);
   endtask

   task automatic test_frame_err();
      for (int i = 0; i < 5; i++) tick(mk(1'b1, 1'b1, i == 0, 1'b0, 1'b0, 1'b0));
      send_word(8'hF0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (frame_err !== 1'b1 || PO !== 8'hF0 || po_valid !== 1'b1) begin
         errors++;
         $display("FAIL frame_err: got fe=%b PO=%h v=%b want fe=1 PO=f0 v=1", frame_err, PO, po_valid);
      end
      idle(1'b1, 1'b1);
      checks++;
      if (frame_err !== 1'b0 || po_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_clr: got fe=%b v=%b want fe=0 v=0", frame_err, po_valid);
      end
   endtask

`ifdef PARITY_EN
   task automatic test_parity();
      send_word(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (parity_err !== 1'b0 || PO !== 8'hA5 || po_valid !== 1'b1) begin
         errors++;
         $display("FAIL parity_good: got pe=%b PO=%h v=%b want pe=0 PO=a5 v=1", parity_err, PO, po_valid);
      end
      idle(1'b1, 1'b0);
      send_word(8'hA7, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (parity_err !== 1'b1 || PO !== 8'hA7 || po_valid !== 1'b1) begin
         errors++;
         $display("FAIL parity_bad: got pe=%b PO=%h v=%b want pe=1 PO=a7 v=1", parity_err, PO, po_valid);
      end
      idle(1'b1, 1'b1);
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_clr: got pe=%b want 0", parity_err);
      end
   endtask
`endif

   task automatic test_random();
      cyc_t q[$];
      cyc_t c;
      bit   d;
      int   nb, g;
      for (int f = 0; f < 300; f++) begin
         q.delete();
         d  = rb();
         nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, NB - 1)) : NB;
         if ($urandom_range(0, 4) == 0) q.push_back(mk(rb(), 1'b1, 1'b0, rb(), 1'b0, 1'b0));
         for (int j = 0; j < nb; j++) begin
            g = rb() ? int'($urandom_range(0, 2)) : 0;
            repeat (g) q.push_back(mk(rb(), 1'b0, rb(), rb(), 1'b0, 1'b0));
            q.push_back(mk(rb(), 1'b1, j == 0, (j == 0) ? d : rb(), 1'b0, 1'b0));
         end
         foreach (q[k]) begin
            c     = q[k];
            c.rdy = ($urandom_range(0, 9) < 6);
            c.clr = ($urandom_range(0, 19) == 0);
            tick(c);
            checks++;
            if (po_valid !== m_valid || (m_valid && PO !== m_po)) begin
               errors++;
               $display("FAIL random_po frame %0d: got v=%b PO=%h want v=%b PO=%h", f, po_valid, PO, m_valid, m_po);
            end
            checks++;
            if ({overrun, frame_err, parity_err} !== {m_ov, m_fe, m_pe}) begin
               errors++;
               $display("FAIL random_flags frame %0d: got ov/fe/pe=%b want %b", f, {overrun, frame_err, parity_err}, {m_ov, m_fe, m_pe});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lsb_first();
      test_msb_gaps();
      test_back_to_back();
      test_frame_err();
`ifdef PARITY_EN
      test_parity();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
